// File: rtl/adc_drv_pkg.sv
// Shared types and constants for the parallel multi-channel ADC driver.
package adc_drv_pkg;

    localparam int unsigned DATA_W_DEF = 16;

    localparam logic WRITE_N_TIE       = 1'b1;
    localparam logic SOFTWARE_MODE_TIE = 1'b0;
    localparam logic SERIAL_MODE_TIE   = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StWaitHi,
        StWaitLo,
        StRd,
        StHold,
        StGap
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/adc_multi_driver.sv
// AD7606-class parallel ADC driver: timer/trigger paced conversions, masked channel
// readback and a valid/ready output stream with RD_N stretched under backpressure.
module adc_multi_driver
    import adc_drv_pkg::*;
#(
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned NUM_CH        = 8,
    parameter int unsigned CH_W          = $clog2(NUM_CH),
    parameter int unsigned SAMPLE_PERIOD = 125,
    parameter int unsigned CONVST_LOW    = 2,
    parameter int unsigned RD_LOW        = 2,
    parameter int unsigned RD_HIGH       = 1,
    parameter int unsigned BUSY_TIMEOUT  = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_busy,
    input  logic [DATA_W-1:0] i_data_adc,
    input  logic              i_enable,
    input  logic              i_trig_mode,
    input  logic              i_trig_in,
    input  logic [NUM_CH-1:0] i_ch_mask,
    output logic              o_chipselect_n,
    output logic              o_read_n,
    output logic              o_write_n,
    output logic              o_software_mode,
    output logic              o_serial_mode,
    output logic              o_standby_n,
    output logic              o_conv_start_a,
    output logic              o_conv_start_b,
    output logic              o_conv_start_c,
    output logic              o_conv_start_d,
    output logic [DATA_W-1:0] o_data_out,
    output logic [CH_W-1:0]   o_ch_idx,
    output logic              o_data_valid,
    input  logic              i_data_ready,
    output logic              o_frame_last,
    output logic              o_overrun,
    output logic              o_timeout
);

    localparam int unsigned TMR_W = $clog2(SAMPLE_PERIOD + 1);
    localparam int unsigned CNT_W = 16;

    localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0] CONV_MAX  = CNT_W'(CONVST_LOW - 1);
    localparam logic [CNT_W-1:0] RDLO_MAX  = CNT_W'(RD_LOW - 1);
    localparam logic [CNT_W-1:0] RDHI_MAX  = CNT_W'(RD_HIGH - 1);
    localparam logic [CNT_W-1:0] BUSY_MAX  = CNT_W'(BUSY_TIMEOUT - 1);

    logic              w_busy_sync;
    logic              w_tick;
    logic              w_event;
    logic [CH_W-1:0]   w_last;

    logic [TMR_W-1:0]  r_timer;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CH_W-1:0]   r_k;
    logic [CH_W-1:0]   r_last;
    logic [NUM_CH-1:0] r_mask;
    logic              r_cs_n;
    logic              r_rd_n;
    logic              r_convst;
    logic              r_standby_n;
    logic [DATA_W-1:0] r_data;
    logic [CH_W-1:0]   r_ch;
    logic              r_valid;
    logic              r_frame_last;
    logic              r_overrun;
    logic              r_timeout;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_busy_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_busy),
        .o_q     (w_busy_sync)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_timer <= '0;
        end else if (!i_enable || r_timer == TMR_MAX) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_tick  = i_enable && (r_timer == TMR_MAX);
    assign w_event = i_trig_mode ? i_trig_in : w_tick;

    // Highest enabled channel bounds the readback; later channels are never read.
    always_comb begin
        w_last = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_ch_mask[i]) begin
                w_last = CH_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_k          <= '0;
            r_last       <= '0;
            r_mask       <= '0;
            r_cs_n       <= 1'b1;
            r_rd_n       <= 1'b1;
            r_convst     <= 1'b1;
            r_standby_n  <= 1'b0;
            r_data       <= '0;
            r_ch         <= '0;
            r_valid      <= 1'b0;
            r_frame_last <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_standby_n <= 1'b1;
            // Any pacing event outside IDLE is dropped, including one coinciding with frame end.
            if (w_event && r_state != StIdle) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_event && i_enable && i_ch_mask != '0) begin
                        r_mask   <= i_ch_mask;
                        r_last   <= w_last;
                        r_convst <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= StConv;
                    end
                end
                StConv: begin
                    if (r_cnt == CONV_MAX) begin
                        r_convst <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= StWaitHi;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWaitHi: begin
                    if (w_busy_sync) begin
                        r_cnt   <= '0;
                        r_state <= StWaitLo;
                    end else if (r_cnt == BUSY_MAX) begin
                        r_timeout <= 1'b1;
                        r_cs_n    <= 1'b1;
                        r_state   <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWaitLo: begin
                    if (!w_busy_sync) begin
                        r_cs_n  <= 1'b0;
                        r_rd_n  <= 1'b0;
                        r_k     <= '0;
                        r_cnt   <= '0;
                        r_state <= StRd;
                    end else if (r_cnt == BUSY_MAX) begin
                        r_timeout <= 1'b1;
                        r_cs_n    <= 1'b1;
                        r_state   <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StRd: begin
                    if (r_cnt == RDLO_MAX) begin
                        r_cnt <= '0;
                        if (r_mask[r_k]) begin
                            r_data       <= i_data_adc;
                            r_ch         <= r_k;
                            r_valid      <= 1'b1;
                            r_frame_last <= (r_k == r_last);
                            r_state      <= StHold;
                        end else begin
                            r_rd_n  <= 1'b1;
                            r_state <= StGap;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StHold: begin
                    if (i_data_ready) begin
                        r_valid      <= 1'b0;
                        r_frame_last <= 1'b0;
                        r_rd_n       <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= StGap;
                    end
                end
                StGap: begin
                    if (r_cnt == RDHI_MAX) begin
                        r_cnt <= '0;
                        if (r_k == r_last) begin
                            r_cs_n  <= 1'b1;
                            r_state <= StIdle;
                        end else begin
                            r_k     <= r_k + 1'b1;
                            r_rd_n  <= 1'b0;
                            r_state <= StRd;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_chipselect_n  = r_cs_n;
    assign o_read_n        = r_rd_n;
    assign o_write_n       = WRITE_N_TIE;
    assign o_software_mode = SOFTWARE_MODE_TIE;
    assign o_serial_mode   = SERIAL_MODE_TIE;
    assign o_standby_n     = r_standby_n;
    assign o_conv_start_a  = r_convst;
    assign o_conv_start_b  = r_convst;
    assign o_conv_start_c  = r_convst;
    assign o_conv_start_d  = r_convst;
    assign o_data_out      = r_data;
    assign o_ch_idx        = r_ch;
    assign o_data_valid    = r_valid;
    assign o_frame_last    = r_frame_last;
    assign o_overrun       = r_overrun;
    assign o_timeout       = r_timeout;

endmodule

// File: tb/tb_adc_multi_driver.sv
// Directed bench for adc_multi_driver with a behavioural AD7606 BUSY/DB model.
module tb_adc_multi_driver;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_busy = 1'b0;
    logic [DATA_W-1:0] data_adc = '0;
    logic              enable = 1'b0;
    logic              trig_mode = 1'b0;
    logic              trig_in = 1'b0;
    logic [NUM_CH-1:0] mask = '1;
    logic              ready = 1'b1;

    logic              cs_n, rd_n, wr_n, sw_mode, ser_mode, stby_n;
    logic              cv_a, cv_b, cv_c, cv_d;
    logic [DATA_W-1:0] dout;
    logic [CH_W-1:0]   ch_idx;
    logic              valid, flast, overrun, tmo;

    int total = 0;
    int bad   = 0;

    adc_multi_driver u_dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_busy          (i_busy),
        .i_data_adc      (data_adc),
        .i_enable        (enable),
        .i_trig_mode     (trig_mode),
        .i_trig_in       (trig_in),
        .i_ch_mask       (mask),
        .o_chipselect_n  (cs_n),
        .o_read_n        (rd_n),
        .o_write_n       (wr_n),
        .o_software_mode (sw_mode),
        .o_serial_mode   (ser_mode),
        .o_standby_n     (stby_n),
        .o_conv_start_a  (cv_a),
        .o_conv_start_b  (cv_b),
        .o_conv_start_c  (cv_c),
        .o_conv_start_d  (cv_d),
        .o_data_out      (dout),
        .o_ch_idx        (ch_idx),
        .o_data_valid    (valid),
        .i_data_ready    (ready),
        .o_frame_last    (flast),
        .o_overrun       (overrun),
        .o_timeout       (tmo)
    );

    always #5 clk = ~clk;

    // ADC model state and observed stream
    logic [15:0] base = 16'h1000;
    bit          busy_en = 1'b0;
    int          cyc = 0;
    int          adc_ch = 0;
    int          rd_falls = 0;
    int          conv_falls = 0;
    int          conv_rise_cyc = 0;
    int          to_cyc = 0;
    bit          valid_seen = 1'b0;
    logic        prev_rd = 1'b1;
    logic        prev_cv = 1'b1;
    logic        prev_to = 1'b0;
    int          conv_fall_cyc[$];
    logic [CH_W-1:0]   q_ch[$];
    logic [DATA_W-1:0] q_data[$];
    logic              q_last[$];

    always @(negedge clk) begin
        cyc++;
        if (valid === 1'b1) valid_seen = 1'b1;
        if (valid === 1'b1 && ready === 1'b1) begin
            q_ch.push_back(ch_idx);
            q_data.push_back(dout);
            q_last.push_back(flast);
        end
        if (prev_rd === 1'b1 && rd_n === 1'b0) rd_falls++;
        if (prev_cv === 1'b1 && cv_a === 1'b0) begin
            conv_falls++;
            conv_fall_cyc.push_back(cyc);
        end
        if (prev_cv === 1'b0 && cv_a === 1'b1) conv_rise_cyc = cyc;
        if (prev_to === 1'b0 && tmo === 1'b1) to_cyc = cyc;
        if (cs_n !== 1'b0) adc_ch = 0;
        else if (prev_rd === 1'b0 && rd_n === 1'b1) adc_ch++;
        data_adc = base + 16'(adc_ch);
        prev_rd = rd_n;
        prev_cv = cv_a;
        prev_to = tmo;
    end

    initial begin
        forever begin
            @(posedge cv_a);
            if (busy_en) begin
                repeat (3) @(posedge clk);
                #1 i_busy = 1'b1;
                repeat (45) @(posedge clk);
                #1 i_busy = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; trig_mode = 1'b0; trig_in = 1'b0; ready = 1'b1; mask = '1;
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 100 && i_busy !== 1'b0; i++) step(1);
        step(2);
        q_ch.delete(); q_data.delete(); q_last.delete(); conv_fall_cyc.delete();
        rd_falls = 0; conv_falls = 0; valid_seen = 1'b0; to_cyc = 0; conv_rise_cyc = 0;
    endtask

    task automatic pulse_trig();
        trig_in = 1'b1;
        step(1);
        trig_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        total++; if (rd_n !== 1'b1) begin bad++; $display("FAIL reset_read_n got=%b want=1", rd_n); end
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b want=1", cs_n); end
        total++; if (wr_n !== 1'b1 || sw_mode !== 1'b0 || ser_mode !== 1'b0) begin bad++;
            $display("FAIL reset_ties got=%b%b%b want=100", wr_n, sw_mode, ser_mode); end
        total++; if ({cv_a, cv_b, cv_c, cv_d} !== 4'hF) begin bad++;
            $display("FAIL reset_convst got=%b%b%b%b want=1111", cv_a, cv_b, cv_c, cv_d); end
        total++; if (stby_n !== 1'b0) begin bad++; $display("FAIL reset_standby got=%b want=0", stby_n); end
        total++; if ({valid, flast, overrun, tmo} !== 4'h0) begin bad++;
            $display("FAIL reset_flags got=%b%b%b%b want=0000", valid, flast, overrun, tmo); end
        total++; if (dout !== 16'h0 || ch_idx !== 3'd0) begin bad++;
            $display("FAIL reset_data got=%h/%0d want=0000/0", dout, ch_idx); end
        rst = 1'b0;
        step(1);
        total++; if (stby_n !== 1'b1) begin bad++; $display("FAIL standby_run got=%b want=1", stby_n); end
    endtask

    task automatic test_full_mask();
        do_reset();
        busy_en = 1'b1; base = 16'h1000; mask = 8'hFF; trig_mode = 1'b0; ready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 450 && q_ch.size() < 16; i++) step(1);
        total++; if (q_ch.size() !== 16) begin bad++; $display("FAIL full_count got=%0d want=16", q_ch.size()); end
        for (int i = 0; i < 16; i++) begin
            total++; if (q_ch[i] !== CH_W'(i % 8)) begin bad++;
                $display("FAIL full_ch[%0d] got=%0d want=%0d", i, q_ch[i], i % 8); end
            total++; if (q_data[i] !== 16'h1000 + 16'(i % 8)) begin bad++;
                $display("FAIL full_data[%0d] got=%h want=%h", i, q_data[i], 16'h1000 + 16'(i % 8)); end
            total++; if (q_last[i] !== ((i % 8) == 7)) begin bad++;
                $display("FAIL full_last[%0d] got=%b want=%b", i, q_last[i], (i % 8) == 7); end
        end
        total++; if (conv_fall_cyc.size() < 2 || conv_fall_cyc[1] - conv_fall_cyc[0] !== 125) begin bad++;
            $display("FAIL full_period got=%0d want=125", conv_fall_cyc.size() < 2 ? -1 :
                     conv_fall_cyc[1] - conv_fall_cyc[0]); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL full_overrun got=%b want=0", overrun); end
        enable = 1'b0;
        step(150);
    endtask

    task automatic test_sparse_mask();
        do_reset();
        base = 16'h2000; mask = 8'b0010_0100; enable = 1'b1;
        for (int i = 0; i < 300 && q_ch.size() < 1; i++) step(1);
        enable = 1'b0;  // dropping enable mid-frame must not truncate it
        for (int i = 0; i < 100 && cs_n !== 1'b1; i++) step(1);
        step(2);
        total++; if (q_ch.size() !== 2) begin bad++; $display("FAIL sparse_count got=%0d want=2", q_ch.size()); end
        total++; if (q_ch[0] !== 3'd2 || q_ch[1] !== 3'd5) begin bad++;
            $display("FAIL sparse_ch got=%0d,%0d want=2,5", q_ch[0], q_ch[1]); end
        total++; if (q_data[0] !== 16'h2002 || q_data[1] !== 16'h2005) begin bad++;
            $display("FAIL sparse_data got=%h,%h want=2002,2005", q_data[0], q_data[1]); end
        total++; if (q_last[0] !== 1'b0 || q_last[1] !== 1'b1) begin bad++;
            $display("FAIL sparse_last got=%b%b want=01", q_last[0], q_last[1]); end
        total++; if (rd_falls !== 6) begin bad++; $display("FAIL sparse_rd_pulses got=%0d want=6", rd_falls); end
        step(200);
        total++; if (conv_falls !== 1) begin bad++; $display("FAIL sparse_stop got=%0d want=1", conv_falls); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] held;
        int errs;
        do_reset();
        base = 16'h3000; mask = 8'hFF; ready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 300 && q_ch.size() < 3; i++) step(1);
        ready = 1'b0;
        for (int i = 0; i < 20 && valid !== 1'b1; i++) step(1);
        total++; if (valid !== 1'b1 || ch_idx !== 3'd3 || dout !== 16'h3003) begin bad++;
            $display("FAIL bp_word got=%b/%0d/%h want=1/3/3003", valid, ch_idx, dout); end
        held = dout;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (rd_n !== 1'b0 || valid !== 1'b1 || dout !== held || ch_idx !== 3'd3) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL bp_stall got=%0d bad cycles want=0", errs); end
        ready = 1'b1;
        for (int i = 0; i < 100 && q_ch.size() < 8; i++) step(1);
        for (int i = 0; i < 50 && cs_n !== 1'b1; i++) step(1);
        total++; if (q_ch.size() !== 8 || q_ch[7] !== 3'd7 || q_last[7] !== 1'b1) begin bad++;
            $display("FAIL bp_frame got=%0d words want=8 ending ch7 last", q_ch.size()); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun got=%b want=1", overrun); end
        enable = 1'b0;
        step(200);
    endtask

    task automatic test_trigger();
        do_reset();
        base = 16'h4000; mask = 8'hFF; trig_mode = 1'b1; enable = 1'b1;
        step(3);
        pulse_trig();
        for (int i = 0; i < 50 && i_busy !== 1'b1; i++) step(1);
        step(4);
        pulse_trig();
        step(250);
        total++; if (q_ch.size() !== 8) begin bad++; $display("FAIL trig_count got=%0d want=8", q_ch.size()); end
        total++; if (conv_falls !== 1) begin bad++; $display("FAIL trig_frames got=%0d want=1", conv_falls); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL trig_overrun got=%b want=1", overrun); end
    endtask

    task automatic test_timeout();
        do_reset();
        busy_en = 1'b0; mask = 8'hFF; trig_mode = 1'b1; enable = 1'b1;
        step(2);
        pulse_trig();
        for (int i = 0; i < 150 && tmo !== 1'b1; i++) step(1);
        step(1);
        total++; if (tmo !== 1'b1) begin bad++; $display("FAIL to_flag got=%b want=1", tmo); end
        total++; if (to_cyc - conv_rise_cyc !== 64) begin bad++;
            $display("FAIL to_delay got=%0d want=64", to_cyc - conv_rise_cyc); end
        total++; if (cs_n !== 1'b1 || rd_falls !== 0) begin bad++;
            $display("FAIL to_bus got=cs%b/rd%0d want=cs1/rd0", cs_n, rd_falls); end
        total++; if (valid_seen !== 1'b0) begin bad++; $display("FAIL to_no_data got=%b want=0", valid_seen); end
        busy_en = 1'b1;
    endtask

    task automatic test_reset_hold();
        do_reset();
        busy_en = 1'b1; base = 16'h6000; mask = 8'hFF; trig_mode = 1'b1; ready = 1'b0; enable = 1'b1;
        step(2);
        pulse_trig();
        for (int i = 0; i < 200 && valid !== 1'b1; i++) step(1);
        total++; if (valid !== 1'b1 || rd_n !== 1'b0) begin bad++;
            $display("FAIL rh_hold got=%b/%b want=1/0", valid, rd_n); end
        rst = 1'b1;
        #2;
        total++; if (valid !== 1'b0 || rd_n !== 1'b1 || cs_n !== 1'b1) begin bad++;
            $display("FAIL rh_bus got=%b%b%b want=011", valid, rd_n, cs_n); end
        total++; if (cv_a !== 1'b1 || cv_d !== 1'b1 || stby_n !== 1'b0) begin bad++;
            $display("FAIL rh_pins got=%b%b%b want=110", cv_a, cv_d, stby_n); end
        step(1);
        ready = 1'b1;
        rst = 1'b0;
        step(20);
        total++; if (q_ch.size() !== 0 || valid !== 1'b0) begin bad++;
            $display("FAIL rh_lost got=%0d words want=0", q_ch.size()); end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_backpressure();
        test_trigger();
        test_timeout();
        test_reset_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
